// File: rtl/bus_trace_monitor.sv
// Passive core/memory bus monitor: logs MMIO-window writes into a FWFT FIFO and
// flags halt on a stop address or cycle-budget timeout. Optional: MON_READ_LOG_EN.
module bus_trace_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WIN_MASK  = 32'h0000_0800,
  parameter logic [ADDR_WIDTH-1:0] WIN_MATCH = 32'h0000_0800,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR = 32'h0000_0FFC,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] bus_address,
  input  logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic [DATA_WIDTH-1:0] log_data,
  output logic                  log_we,
  output logic                  running,
  output logic                  halted,
  output logic [1:0]            halt_cause,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic [31:0]           cycle_count
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = PW + 1;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(FIFO_DEPTH);
  localparam logic [31:0]      TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state_r, state_s;
  logic   start_acc_s;
  logic [1:0] cause_s;

  logic running_r, halted_r, overflow_r;
  logic [1:0]  halt_cause_r;
  logic [15:0] drop_count_r;
  logic [31:0] cycle_count_r;

  logic run_s, win_s, hit_s, halt_addr_s, timeout_s;

  logic [EW-1:0]    mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, count_s, free_s;
  logic [PW-1:0]    idx0_s, idx1_s;
  logic [EW-1:0]    head_s;
  logic             pop_s, valid_s, acc0_s, acc1_s;
  logic [1:0]       drop_n_s;
  logic [16:0]      drop_sum_s;

  // Entry 0 is a completing read (older), entry 1 is this cycle's write hit.
  logic                  rpush_s;
  logic [ADDR_WIDTH-1:0] rpush_addr_s;
  logic [DATA_WIDTH-1:0] rpush_data_s;

  assign run_s       = (state_r == ST_RUN);
  assign win_s       = ((bus_address & WIN_MASK) == WIN_MATCH);
  assign hit_s       = run_s && bus_we && win_s;
  assign halt_addr_s = run_s && (bus_address == HALT_ADDR);
  assign timeout_s   = run_s && (TIMEOUT_CYCLES != 0) && (cycle_count_r == TO_LAST);

`ifdef MON_READ_LOG_EN
  logic                  pend_v_r;
  logic [ADDR_WIDTH-1:0] pend_addr_r;

  // One-entry pending read: address now, read data arrives next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v_r    <= 1'b0;
      pend_addr_r <= '0;
    end else begin
      pend_v_r    <= run_s && !bus_we && win_s;
      pend_addr_r <= bus_address;
    end
  end

  assign rpush_s      = pend_v_r;
  assign rpush_addr_s = pend_addr_r;
  assign rpush_data_s = bus_rdata;
`else
  logic unused_rdata_s;
  assign unused_rdata_s = ^bus_rdata;
  assign rpush_s        = 1'b0;
  assign rpush_addr_s   = '0;
  assign rpush_data_s   = '0;
`endif

  // Next-state logic; halt address outranks timeout.
  always_comb begin
    state_s     = state_r;
    start_acc_s = 1'b0;
    cause_s     = halt_cause_r;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_s     = ST_RUN;
          start_acc_s = 1'b1;
          cause_s     = 2'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (halt_addr_s) begin
          state_s = ST_HALTED;
          cause_s = 2'd1;
        end else if (timeout_s) begin
          state_s = ST_HALTED;
          cause_s = 2'd2;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cause_s = 2'd0;
      end
    endcase
  end

  // FIFO occupancy and admission of up to two pushes per cycle.
  always_comb begin
    count_s    = wr_ptr_r - rd_ptr_r;
    valid_s    = (count_s != '0);
    pop_s      = valid_s && log_ready;
    free_s     = DEPTH_P - count_s + PTR_W'(pop_s);
    acc0_s     = rpush_s && (free_s != '0);
    acc1_s     = hit_s && (free_s > PTR_W'(acc0_s));
    drop_n_s   = 2'(rpush_s && !acc0_s) + 2'(hit_s && !acc1_s);
    drop_sum_s = 17'(drop_count_r) + 17'(drop_n_s);
    idx0_s     = wr_ptr_r[PW-1:0];
    idx1_s     = wr_ptr_r[PW-1:0] + PW'(acc0_s);
    head_s     = mem_r[rd_ptr_r[PW-1:0]];
  end

  // Control/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      running_r     <= 1'b0;
      halted_r      <= 1'b0;
      halt_cause_r  <= 2'd0;
      overflow_r    <= 1'b0;
      drop_count_r  <= 16'd0;
      cycle_count_r <= 32'd0;
    end else begin
      state_r      <= state_s;
      running_r    <= (state_s == ST_RUN);
      halted_r     <= (state_s == ST_HALTED);
      halt_cause_r <= cause_s;
      if (start_acc_s) begin
        overflow_r    <= 1'b0;
        drop_count_r  <= 16'd0;
        cycle_count_r <= 32'd0;
      end else begin
        if (run_s) begin
          cycle_count_r <= cycle_count_r + 32'd1;
        end
        if (drop_n_s != 2'd0) begin
          overflow_r   <= 1'b1;
          drop_count_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
      end
    end
  end

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(acc0_s) + PTR_W'(acc1_s);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
    end
  end

  // FIFO storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (acc0_s) begin
      mem_r[idx0_s] <= {rpush_addr_s, rpush_data_s, 1'b0};
    end
    if (acc1_s) begin
      mem_r[idx1_s] <= {bus_address, bus_wdata, 1'b1};
    end
  end

  assign log_valid   = valid_s;
  assign log_addr    = valid_s ? head_s[EW-1:DATA_WIDTH+1] : '0;
  assign log_data    = valid_s ? head_s[DATA_WIDTH:1] : '0;
  assign log_we      = valid_s && head_s[0];
  assign running     = running_r;
  assign halted      = halted_r;
  assign halt_cause  = halt_cause_r;
  assign overflow    = overflow_r;
  assign drop_count  = drop_count_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_bus_trace_monitor.sv
// Directed self-checking bench for bus_trace_monitor (TIMEOUT_CYCLES=16).
module tb_bus_trace_monitor;
  logic        clk = 1'b0;
  logic        reset, start, bus_we, log_ready;
  logic [31:0] bus_address, bus_wdata, bus_rdata;
  logic        log_valid, log_we, running, halted, overflow;
  logic [31:0] log_addr, log_data, cycle_count;
  logic [1:0]  halt_cause;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int n;

  bus_trace_monitor #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .bus_address(bus_address), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .log_valid(log_valid), .log_ready(log_ready),
    .log_addr(log_addr), .log_data(log_data), .log_we(log_we),
    .running(running), .halted(halted), .halt_cause(halt_cause),
    .overflow(overflow), .drop_count(drop_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_address = 32'h0;
    bus_we      = 1'b0;
    bus_wdata   = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_address = a;
    bus_we      = 1'b1;
    bus_wdata   = d;
    tick();
    bus_idle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; log_ready = 1'b0; bus_rdata = 32'h0;
    bus_idle();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_valid", 64'(log_valid), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_cause", 64'(halt_cause), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_cyc", 64'(cycle_count), 64'd0);
    check("rst_addr", 64'(log_addr), 64'd0);
    check("rst_we", 64'(log_we), 64'd0);

    // Basic logging with consumer always ready; run then times out.
    log_ready = 1'b1;
    pulse_start();
    n = 0;
    check("t2_running", 64'(running), 64'd1);
    wr(32'h800, 32'h11); n++;
    check("t2_v1", 64'(log_valid), 64'd1);
    check("t2_a1", 64'(log_addr), 64'h800);
    check("t2_d1", 64'(log_data), 64'h11);
    check("t2_we1", 64'(log_we), 64'd1);
    wr(32'h804, 32'h22); n++;
    check("t2_a2", 64'(log_addr), 64'h804);
    check("t2_d2", 64'(log_data), 64'h22);
    wr(32'h400, 32'h33); n++;
    check("t2_nolog", 64'(log_valid), 64'd0);
    while (!halted && n < 40) begin tick(); n++; end
    check("t2_to_cycles", 64'(n), 64'd16);
    check("t2_cause", 64'(halt_cause), 64'd2);
    check("t2_cyc", 64'(cycle_count), 64'd16);
    check("t2_running", 64'(running), 64'd0);

    // Fill, push-while-full with pop, then overflow and full drain.
    log_ready = 1'b0;
    pulse_start();
    n = 0;
    check("t3_cause_clr", 64'(halt_cause), 64'd0);
    check("t3_cyc_clr", 64'(cycle_count), 64'd0);
    for (int i = 0; i < 8; i++) begin wr(32'h800 + 32'(4*i), 32'h100 + 32'(i)); n++; end
    check("t3_full_ovf", 64'(overflow), 64'd0);
    check("t3_head0", 64'(log_addr), 64'h800);
    log_ready = 1'b1;
    wr(32'h820, 32'h108); n++;
    log_ready = 1'b0;
    check("t3_pp_ovf", 64'(overflow), 64'd0);
    check("t3_head1", 64'(log_addr), 64'h804);
    wr(32'h824, 32'h109); n++;
    wr(32'h828, 32'h10A); n++;
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_drop", 64'(drop_count), 64'd2);
    while (!halted && n < 40) begin tick(); n++; end
    check("t3_halt", 64'(halted), 64'd1);
    log_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_drain_v", 64'(log_valid), 64'd1);
      check("t3_drain_a", 64'(log_addr), 64'(32'h804 + 32'(4*i)));
      check("t3_drain_d", 64'(log_data), 64'(32'h101 + 32'(i)));
      tick();
    end
    check("t3_empty", 64'(log_valid), 64'd0);
    check("t3_drop_hold", 64'(drop_count), 64'd2);
    check("t4_ovf_before", 64'(overflow), 64'd1);

    // Halt address with a window write in the same cycle.
    pulse_start();
    check("t4_ovf_clr", 64'(overflow), 64'd0);
    check("t4_drop_clr", 64'(drop_count), 64'd0);
    wr(32'h810, 32'h0A);
    check("t4_a810", 64'(log_addr), 64'h810);
    wr(32'hFFC, 32'h55);
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_cause", 64'(halt_cause), 64'd1);
    check("t4_aFFC", 64'(log_addr), 64'hFFC);
    check("t4_dFFC", 64'(log_data), 64'h55);
    check("t4_cyc", 64'(cycle_count), 64'd2);
    repeat (3) tick();
    check("t4_cyc_frozen", 64'(cycle_count), 64'd2);
    pulse_start();
    check("t4_rerun", 64'(running), 64'd1);
    check("t4_cause_clr", 64'(halt_cause), 64'd0);

    // Halt address coinciding with the timeout cycle.
    repeat (15) tick();
    check("t5_cyc15", 64'(cycle_count), 64'd15);
    bus_address = 32'hFFC;
    tick();
    bus_idle();
    check("t5_halted", 64'(halted), 64'd1);
    check("t5_cause", 64'(halt_cause), 64'd1);
    check("t5_cyc", 64'(cycle_count), 64'd16);

    // Start ignored in RUN, then reset with 5 entries queued.
    log_ready = 1'b0;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    check("t6_start_ign", 64'(cycle_count), 64'd4);
    check("t6_running", 64'(running), 64'd1);
    for (int i = 0; i < 5; i++) wr(32'h900 + 32'(4*i), 32'h200 + 32'(i));
    check("t6_valid", 64'(log_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", 64'(log_valid), 64'd0);
    check("t6_rst_running", 64'(running), 64'd0);
    check("t6_rst_halted", 64'(halted), 64'd0);
    check("t6_rst_cyc", 64'(cycle_count), 64'd0);
    check("t6_rst_addr", 64'(log_addr), 64'd0);
    reset = 1'b0;
    tick();
    check("t6_idle_valid", 64'(log_valid), 64'd0);

`ifdef MON_READ_LOG_EN
    pulse_start();
    bus_address = 32'h808;
    bus_we      = 1'b0;
    tick();
    bus_idle();
    bus_rdata = 32'hBEEF;
    tick();
    bus_rdata = 32'h0;
    check("t7_rd_valid", 64'(log_valid), 64'd1);
    check("t7_rd_addr", 64'(log_addr), 64'h808);
    check("t7_rd_data", 64'(log_data), 64'hBEEF);
    check("t7_rd_we", 64'(log_we), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_trace_monitor.md
Name: bus_trace_monitor

Overview:
- Synthesizable, parametrised successor to the simulation-only bus watcher on the core-to-memory bus.
- Passively samples address, we and write data on the core/memory interface.
- Logs writes that fall in a configurable MMIO window into a FIFO that can be drained with a valid/ready handshake.
- Flags a halt on a programmable stop address or on a cycle-budget timeout, so the same halt/trace logic works in simulation and on FPGA.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width.
- WIN_MASK, 32'h0000_0800, address bits compared for window membership.
- WIN_MATCH, 32'h0000_0800, required value of masked bits (default: address[11]==1).
- HALT_ADDR, 32'h0000_0FFC, address whose appearance ends the run.
- FIFO_DEPTH, 8, log entries; power of two, >=2.
- TIMEOUT_CYCLES, 4000, RUN cycles before forced halt; 0 disables timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: arm/re-arm monitor
- bus_address  in  ADDR_WIDTH  core address
- bus_we  in  1  core write enable
- bus_wdata  in  DATA_WIDTH  core write data (core data_out)
- bus_rdata  in  DATA_WIDTH  memory read data (used only with optional feature)
- log_valid  out  1  FIFO head valid
- log_ready  in  1  consumer accepts head
- log_addr  out  ADDR_WIDTH  head address
- log_data  out  DATA_WIDTH  head data
- log_we  out  1  head is a write (constant 1 without optional feature)
- running  out  1  state==RUN
- halted  out  1  state==HALTED
- halt_cause  out  2  0 none, 1 halt address, 2 timeout
- overflow  out  1  sticky: at least one entry dropped
- drop_count  out  16  dropped entries, saturating at 16'hFFFF
- cycle_count  out  32  cycles spent in RUN since last start

Behaviour:
- Reset (highest priority over all inputs): state IDLE, FIFO empty, log_valid=0, log_addr/log_data=0, log_we=0, running=0, halted=0, halt_cause=0, overflow=0, drop_count=0, cycle_count=0.
- FSM states: IDLE, RUN, HALTED.
  - IDLE -start-> RUN.
  - RUN -halt/timeout-> HALTED.
  - HALTED -start-> RUN.
  - start while in RUN is ignored.
- On entry to RUN (start accepted): cycle_count, halt_cause, overflow and drop_count clear to 0. FIFO contents are kept; only reset flushes the FIFO.
- Sampling happens only in RUN, on each rising edge:
  - hit = bus_we && ((bus_address & WIN_MASK) == WIN_MATCH).
  - On hit, push {bus_address, bus_wdata, 1}.
  - Capture-to-log_valid latency: 1 cycle if FIFO was empty.
- FIFO is first-word-fall-through. Pop occurs when log_valid && log_ready. Popping is allowed in every state, including IDLE and HALTED.
- Push when full:
  - If a pop occurs the same cycle, the push succeeds and no overflow is flagged.
  - Otherwise the entry is dropped, overflow sets to 1 and drop_count increments (saturating).
- Push and pop on an empty FIFO in the same cycle: the new entry is stored; log_valid goes 1 the next cycle.
- Read/write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- cycle_count increments by 1 each RUN cycle and holds its value in HALTED and IDLE.
- Halt address: bus_address == HALT_ADDR in RUN.
  - Next state is HALTED, halt_cause=1.
  - A window hit in that same cycle is still captured.
- Timeout: in RUN with TIMEOUT_CYCLES != 0 and cycle_count == TIMEOUT_CYCLES-1.
  - Next state is HALTED, halt_cause=2.
  - If halt address and timeout occur in the same cycle, halt_cause=1 (address wins).
- running/halted are registered and reflect the state from the cycle after the transition.
- Reset asserted mid-RUN or with a non-empty FIFO: everything returns to reset values on the next edge; in-flight entries are lost.

Optional Feature:
- MON_READ_LOG_EN defined:
  - Window reads are also logged. A window read is bus_we=0 with the masked address matching.
  - A read at cycle N pushes {address sampled at N, bus_rdata sampled at N+1, 0}. The address is held in a one-entry pending register.
  - A pending read still completes its push in the cycle after entering HALTED.
  - Reads are subject to the same overflow rules as writes.
- MON_READ_LOG_EN undefined: reads are ignored, bus_rdata is unused and log_we is constant 1 for valid entries.

Test Plan:
- Reset asserted 3 cycles, then idle → all outputs 0, state IDLE.
- start, then writes 0x11 to 0x800, 0x22 to 0x804 and 0x33 to 0x400, with log_ready=1 → exactly two entries (0x800/0x11, 0x804/0x22) with log_we=1; 0x400 is not logged.
- log_ready=0, 10 window writes with FIFO_DEPTH=8 → 8 entries retained, overflow=1, drop_count=2. Then a full drain returns entries in order.
- Window write to 0xFFC with HALT_ADDR=0xFFC → HALTED, halt_cause=1, entry logged, cycle_count frozen; a later start clears cause/overflow and re-enters RUN.
- TIMEOUT_CYCLES=16, no halt address → halted after 16 RUN cycles, cycle_count=16, halt_cause=2. Same setup with HALT_ADDR presented on the 16th cycle → halt_cause=1.
- Reset pulse while FIFO holds 5 entries in RUN → log_valid=0 next cycle, IDLE; with MON_READ_LOG_EN, a window read of 0x808 logs rdata from the following cycle with log_we=0.
